fix_div: RTL and testbench

Iterative signed fixed-point divider for the SVM datapath. It computes the Q16.16 quotient of two 32-bit two's-complement operands and is the inverse of the pipelined fixed-point multiplier. It serves decision-value normalisation and kernel-scaling steps, using a start/busy/done handshake toward the SVM controller. The core is a restoring divider that resolves one quotient bit per cycle, with saturation on overflow and divide-by-zero.

---
 rtl/fix_pkg.sv | 17 +
 rtl/fix_abs_sign.sv | 16 +
 rtl/fix_div.sv | 146 ++++++++++++++
 tb/tb_fix_div.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared fixed-point definitions for the SVM datapath (divider and multiplier).
// Holds the Q16.16 format constants and the divider state encoding.
package fix_pkg;

  localparam int FIX_WIDTH = 32;
  localparam int FIX_FRAC  = 16;

  localparam logic [FIX_WIDTH-1:0] FIX_MAX = 32'h7FFF_FFFF;
  localparam logic [FIX_WIDTH-1:0] FIX_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } fix_state_t;

endpackage

// File: rtl/fix_abs_sign.sv
// Splits a two's-complement value into an unsigned magnitude and a sign bit.
// The most negative value maps to 2^(WIDTH-1), which still fits the magnitude.
module fix_abs_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign o_sign = i_value[WIDTH-1];
  assign o_mag  = o_sign ? (~i_value + ONE) : i_value;

endmodule

// File: rtl/fix_div.sv
// Iterative signed Q16.16 divider: restoring division, one quotient bit per cycle,
// saturating on overflow and divide-by-zero, with a start/busy/done handshake.
module fix_div
  import fix_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0]    LAST_ITER = CW'(QW - 1);
  localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  fix_state_t       r_state;
  logic [CW-1:0]    r_count;
  logic [QW-1:0]    r_shift;
  logic [QW-1:0]    r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_abs_dvs;
  logic             r_sign;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic             r_overflow;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_dvd_sign;
  logic             w_dvs_sign;
  logic             w_dvs_zero;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_pos_ovf;
  logic             w_neg_ovf;
  logic [WIDTH-1:0] w_q_neg;

  fix_abs_sign #(.WIDTH(WIDTH)) u_abs_dvd (
    .i_value (dividend),
    .o_mag   (w_dvd_mag),
    .o_sign  (w_dvd_sign)
  );

  fix_abs_sign #(.WIDTH(WIDTH)) u_abs_dvs (
    .i_value (divisor),
    .o_mag   (w_dvs_mag),
    .o_sign  (w_dvs_sign)
  );

  assign w_dvs_zero = (divisor == '0);

  // Working remainder is WIDTH+1 bits; a borrow out of the subtraction means remainder < divisor.
  assign w_rem_shift = {r_rem, r_shift[QW-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_abs_dvs};
  assign w_ge        = ~w_diff[WIDTH];

  assign w_pos_ovf = |r_q[QW-1:WIDTH-1];
  assign w_neg_ovf = (|r_q[QW-1:WIDTH]) | (r_q[WIDTH-1] & (|r_q[WIDTH-2:0]));
  assign w_q_neg   = ~r_q[WIDTH-1:0] + ONE;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_shift       <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_abs_dvs     <= '0;
      r_sign        <= 1'b0;
      r_dz          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_shift   <= {w_dvd_mag, {FRAC{1'b0}}};
            r_abs_dvs <= w_dvs_mag;
            r_sign    <= w_dvd_sign ^ w_dvs_sign;
            r_rem     <= '0;
            r_q       <= '0;
            r_count   <= '0;
            r_dz      <= w_dvs_zero;
            r_state   <= w_dvs_zero ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          r_rem   <= w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
          r_q     <= {r_q[QW-2:0], w_ge};
          r_shift <= {r_shift[QW-2:0], 1'b0};
          r_count <= r_count + CW'(1);
          if (r_count == LAST_ITER) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          // With a zero divisor r_sign is the dividend sign and r_shift still holds |dividend|.
          if (r_dz) begin
            r_quotient    <= (r_shift == '0) ? '0 : (r_sign ? SAT_MIN : SAT_MAX);
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b1;
          end else if (!r_sign) begin
            r_quotient    <= w_pos_ovf ? SAT_MAX : r_q[WIDTH-1:0];
            r_overflow    <= w_pos_ovf;
            r_div_by_zero <= 1'b0;
          end else begin
            r_quotient    <= w_neg_ovf ? SAT_MIN : w_q_neg;
            r_overflow    <= w_neg_ovf;
            r_div_by_zero <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_fix_div.sv
// Scoreboard bench for fix_div: the driver queues hand-computed results and done-cycle
// expectations; an independent monitor pops and compares on every done pulse.
module tb_fix_div;
  import fix_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dz;
    int          cyc;
    int          busy_len;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  fix_div u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measures each busy window and checks every done pulse against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        n_done++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with empty queue at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          check("done_cycle", cyc, e.cyc);
          check("busy_len", busy_run, e.busy_len);
        end
        busy_run = 0;
      end
    end
  end

  // Called at negedge+1; the accept edge is the next posedge.
  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic [31:0] q, input logic ovf, input logic dz);
    exp_t e;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.q        = q;
    e.ovf      = ovf;
    e.dz       = dz;
    e.cyc      = cyc + (dz ? 2 : 50);
    e.busy_len = dz ? 1 : 49;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (n_done >= target) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: done count %0d, required %0d", n_done, target);
    end
  endtask

  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] q, input logic ovf, input logic dz);
    int target;
    target = n_done + 1;
    @(negedge clk);
    #1;
    issue(dvd, dvs, q, ovf, dz);
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(target);
  endtask

  initial begin
    int saved;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    #1;
    rst_n = 1'b1;

    run_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);
    run_op(32'hFFFA_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, 1'b0);
    run_op(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
    run_op(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0);
    run_op(32'h7FFF_0000, 32'h0000_0100, FIX_MAX,       1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0001_0000, FIX_MIN,       1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_8000, FIX_MIN,       1'b1, 1'b0);
    run_op(32'hFFFF_0000, 32'hFFFE_0000, 32'h0000_8000, 1'b0, 1'b0);
    run_op(32'hFFFF_0000, 32'h0000_0000, FIX_MIN,       1'b0, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op(32'h0005_0000, 32'h0000_0000, FIX_MAX,       1'b0, 1'b1);
    run_op(32'h0000_0000, 32'h0003_0000, 32'h0000_0000, 1'b0, 1'b0);

    // A second start ten cycles into an operation must be ignored.
    saved = n_done;
    @(negedge clk);
    #1;
    issue(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("busy_mid_op", 32'(busy), 32'd1);
    dividend = 32'hFFFA_0000;
    divisor  = 32'h0002_0000;
    start    = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(saved + 1);
    check("ignored_start_result", quotient, 32'h0001_8000);
    repeat (55) @(negedge clk);
    #1;
    check("no_extra_done", n_done, saved + 1);

    // Start held high: three back-to-back operations, dones 50 cycles apart.
    saved = n_done;
    @(negedge clk);
    #1;
    issue(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);
    wait_done(saved + 1);
    issue(32'hFFFA_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, 1'b0);
    wait_done(saved + 2);
    issue(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0);
    wait_done(saved + 3);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("held_start_count", n_done, saved + 3);

    // Reset twenty cycles into an operation aborts it without a done pulse.
    saved = n_done;
    @(negedge clk);
    #1;
    issue(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (18) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("abort_no_done", n_done, saved);
    check("abort_idle_busy", 32'(busy), 32'd0);
    run_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);

    check("queue_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
